i2c_slave_regfile: RTL

//  Parametrised I2C target with START/STOP detection, MSB-first bytes, read and write transfers.

---
 rtl/i2c_slave_regfile.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/i2c_slave_regfile.sv
// rtl/i2c_slave_regfile.sv - I2C target exposing a byte register file with auto-incrementing pointer
// Optional GENERAL_CALL_EN: accept general-call address 0x00 and software reset command 0x06.
module i2c_slave_regfile #(
  parameter int NUM_REGS    = 16,
  parameter int SYNC_STAGES = 2,
  localparam int PTR_W      = $clog2(NUM_REGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       own_addr,
  input  logic             scl,
  inout  wire              sda,
  input  logic [PTR_W-1:0] rd_addr,
  output logic [7:0]       rd_data,
  output logic             wr_strobe,
  output logic [PTR_W-1:0] wr_addr,
  output logic [7:0]       wr_data,
  output logic             busy,
  output logic             start_det,
  output logic             stop_det
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK,
    RDATA, RDATA_ACK, WAIT, GCMD, GCMD_ACK
  } state_t;

  state_t                 state, ack_next;
  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic                   scl_q, sda_q;
  logic [7:0]             regs [NUM_REGS];
  logic [PTR_W-1:0]       ptr;
  logic [7:0]             shreg;
  logic [3:0]             bitcnt;
  logic                   ack_on;
  logic                   sda_oe;

  logic scl_s, sda_s, scl_rise, scl_fall, start_c, stop_c, last_bit, addr_match;
  logic [7:0] byte_in;

  // Open-drain: the only value this target ever puts on the bus is 0.
  assign sda = sda_oe ? 1'b0 : 1'bz;

  assign scl_s      = scl_sync[SYNC_STAGES-1];
  assign sda_s      = sda_sync[SYNC_STAGES-1];
  assign scl_rise   = scl_s & ~scl_q;
  assign scl_fall   = ~scl_s & scl_q;
  assign start_c    = scl_s & scl_q & sda_q & ~sda_s;
  assign stop_c     = scl_s & scl_q & ~sda_q & sda_s;
  assign byte_in    = {shreg[6:0], sda_s};
  assign last_bit   = scl_rise && (bitcnt == 4'd7);
  assign addr_match = (byte_in[7:1] == own_addr) && (byte_in[7:1] != 7'd0);
  assign rd_data    = regs[rd_addr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_q    <= 1'b1;
      sda_q    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda};
      scl_q    <= scl_s;
      sda_q    <= sda_s;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ack_next  <= IDLE;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= 8'h00;
      ptr       <= '0;
      shreg     <= 8'h00;
      bitcnt    <= 4'd0;
      ack_on    <= 1'b0;
      sda_oe    <= 1'b0;
      wr_strobe <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= 8'h00;
      busy      <= 1'b0;
      start_det <= 1'b0;
      stop_det  <= 1'b0;
    end else begin
      wr_strobe <= 1'b0;
      start_det <= 1'b0;
      stop_det  <= 1'b0;
      // Bus conditions pre-empt whatever the state machine would do with a coincident edge.
      if (start_c) begin
        start_det <= 1'b1;
        state     <= ADDR;
        bitcnt    <= 4'd0;
        ack_on    <= 1'b0;
        sda_oe    <= 1'b0;
        busy      <= 1'b0;
      end else if (stop_c) begin
        stop_det <= 1'b1;
        state    <= IDLE;
        bitcnt   <= 4'd0;
        ack_on   <= 1'b0;
        sda_oe   <= 1'b0;
        busy     <= 1'b0;
      end else begin
        case (state)
          ADDR: if (scl_rise) begin
            shreg  <= byte_in;
            bitcnt <= bitcnt + 4'd1;
            if (last_bit) begin
              bitcnt <= 4'd0;
              ack_on <= 1'b0;
              if (addr_match) begin
                state    <= ADDR_ACK;
                ack_next <= byte_in[0] ? RDATA : PTR;
                busy     <= 1'b1;
              end
`ifdef GENERAL_CALL_EN
              else if (byte_in == 8'h00) begin
                state    <= ADDR_ACK;
                ack_next <= GCMD;
              end
`endif
              else begin
                state <= WAIT;
              end
            end
          end

          PTR: if (scl_rise) begin
            shreg  <= byte_in;
            bitcnt <= bitcnt + 4'd1;
            if (last_bit) begin
              bitcnt   <= 4'd0;
              ack_on   <= 1'b0;
              ptr      <= byte_in[PTR_W-1:0];
              state    <= PTR_ACK;
              ack_next <= WDATA;
            end
          end

          WDATA: if (scl_rise) begin
            shreg  <= byte_in;
            bitcnt <= bitcnt + 4'd1;
            if (last_bit) begin
              bitcnt    <= 4'd0;
              ack_on    <= 1'b0;
              regs[ptr] <= byte_in;
              wr_strobe <= 1'b1;
              wr_addr   <= ptr;
              wr_data   <= byte_in;
              ptr       <= ptr + PTR_W'(1);
              state     <= WDATA_ACK;
              ack_next  <= WDATA;
            end
          end

`ifdef GENERAL_CALL_EN
          GCMD: if (scl_rise) begin
            shreg  <= byte_in;
            bitcnt <= bitcnt + 4'd1;
            if (last_bit) begin
              bitcnt <= 4'd0;
              ack_on <= 1'b0;
              if (byte_in == 8'h06) begin
                for (int i = 0; i < NUM_REGS; i++) regs[i] <= 8'h00;
                ptr      <= '0;
                state    <= GCMD_ACK;
                ack_next <= WAIT;
              end else begin
                state <= WAIT;
              end
            end
          end
`endif

          // First fall after bit 8 pulls SDA low; the next fall ends the ACK slot.
          ADDR_ACK, PTR_ACK, WDATA_ACK, GCMD_ACK: if (scl_fall) begin
            ack_on <= ~ack_on;
            sda_oe <= ~ack_on;
            if (ack_on) begin
              state  <= ack_next;
              bitcnt <= 4'd0;
              if (ack_next == RDATA) begin
                shreg  <= {regs[ptr][6:0], 1'b0};
                sda_oe <= ~regs[ptr][7];
              end
            end
          end

          RDATA: begin
            if (scl_rise) bitcnt <= bitcnt + 4'd1;
            if (scl_fall) begin
              if (bitcnt == 4'd8) begin
                sda_oe <= 1'b0;
                ptr    <= ptr + PTR_W'(1);
                state  <= RDATA_ACK;
              end else begin
                sda_oe <= ~shreg[7];
                shreg  <= {shreg[6:0], 1'b0};
              end
            end
          end

          RDATA_ACK: if (scl_rise) begin
            bitcnt <= 4'd0;
            if (!sda_s) begin
              state <= RDATA;
              shreg <= regs[ptr];
            end else begin
              state <= WAIT;
              busy  <= 1'b0;
            end
          end

          IDLE, WAIT: ;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
